// File: rtl/k005297_pkg.sv
// Shared definitions for the K005297 page comparator slice: state encoding,
// rotation slot indices and the debug view of the compare FSM.
package k005297_pkg;

  localparam int PAGE_W       = 12;
  localparam int TRY_W        = 12;
  localparam int IDX_W        = 4;

  localparam int SLOT_CNT_ADV = 19;
  localparam int SHIFT_FIRST  = 0;
  localparam int SHIFT_LAST   = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_SHIFTIN = 2'd2,
    ST_RESOLVE = 2'd3
  } pgcmp_state_t;

  typedef struct packed {
    pgcmp_state_t       state;
    logic [IDX_W-1:0]   bit_idx;
    logic [TRY_W-1:0]   try_cnt;
    logic               mismatch;
  } pgcmp_dbg_t;

endpackage

// File: rtl/k005297_poscnt.sv
// Bubble page-position counter: wraps to 0 after PAGE_MAX, clear wins over advance.
module k005297_poscnt
  import k005297_pkg::*;
#(
  parameter int PAGE_MAX = 2052
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ce,
  input  logic              i_adv,
  input  logic              i_clr,
  output logic [PAGE_W-1:0] o_cnt
);

  localparam logic [PAGE_W-1:0] LP_PAGE_MAX = PAGE_W'(PAGE_MAX);

  logic [PAGE_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_ce) begin
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_adv) begin
        r_cnt <= (r_cnt == LP_PAGE_MAX) ? '0 : r_cnt + PAGE_W'(1);
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/k005297_pgcmp.sv
// Serial page-position comparator: matches the LSB-first page stream from the
// page register against the position counter, one bit per 2 MHz enable.
module k005297_pgcmp
  import k005297_pkg::*;
#(
  parameter int PAGE_MAX = 2052,
  parameter int TRY_MAX  = 2053
) (
  input  logic              i_MCLK,
  input  logic              i_SYS_RST_n,
  input  logic              i_CLK2M_PCEN_n,
  input  logic [19:0]       i_ROT20_n,
  input  logic              i_PGREG_SR_SHIFT,
  input  logic              i_PGREG_SR_LSB,
  input  logic              i_POSCNT_CLR,
  input  logic              i_POSCNT_EN,
  input  logic              i_CMP_START,
  input  logic              i_CMP_ABORT,
  output logic [PAGE_W-1:0] o_POSCNT,
  output logic              o_PGCMP_BUSY,
  output logic              o_PGCMP_MATCH,
  output logic              o_PGCMP_TIMEOUT,
  output pgcmp_dbg_t        o_DBG
);

  localparam logic [TRY_W-1:0] LP_TRY_LAST = TRY_W'(TRY_MAX - 1);
  localparam logic [IDX_W-1:0] LP_IDX_LAST = IDX_W'(SHIFT_LAST);

  logic              w_ce;
  logic              w_adv;
  logic [PAGE_W-1:0] w_poscnt;
  logic              w_mis_first;
  logic              w_mis_bit;
  logic              w_unused_rot;

  pgcmp_state_t      r_state;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [TRY_W-1:0]  r_try;
  logic              r_mis;
  logic              r_match;
  logic              r_timeout;

  assign w_ce  = ~i_CLK2M_PCEN_n;
  assign w_adv = ~i_ROT20_n[SLOT_CNT_ADV] & i_POSCNT_EN;
  // Only the advance slot is decoded here; the rest of the rotation is upstream's business.
  assign w_unused_rot = ^i_ROT20_n[SLOT_CNT_ADV-1:0];

  k005297_poscnt #(
    .PAGE_MAX (PAGE_MAX)
  ) u_poscnt (
    .i_clk   (i_MCLK),
    .i_rst_n (i_SYS_RST_n),
    .i_ce    (w_ce),
    .i_adv   (w_adv),
    .i_clr   (i_POSCNT_CLR),
    .o_cnt   (w_poscnt)
  );

  // The counter only moves in slot 19, so it is stable across the 12-bit window.
  assign w_mis_first = i_PGREG_SR_LSB ^ w_poscnt[SHIFT_FIRST];
  assign w_mis_bit   = i_PGREG_SR_LSB ^ w_poscnt[r_bit_idx];

  // START and ABORT are levels sampled on enable edges; ABORT wins and never emits MATCH/TIMEOUT.
  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
    if (!i_SYS_RST_n) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= '0;
      r_try     <= '0;
      r_mis     <= 1'b0;
      r_match   <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_ce) begin
      r_match <= 1'b0;
      if (i_CMP_ABORT) begin
        r_state   <= ST_IDLE;
        r_bit_idx <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_CMP_START) begin
              r_state   <= ST_ARMED;
              r_try     <= '0;
              r_timeout <= 1'b0;
              r_bit_idx <= '0;
            end
          end
          ST_ARMED: begin
            if (i_PGREG_SR_SHIFT) begin
              r_mis     <= w_mis_first;
              r_bit_idx <= IDX_W'(1);
              r_state   <= ST_SHIFTIN;
            end
          end
          ST_SHIFTIN: begin
            if (i_PGREG_SR_SHIFT) begin
              r_mis <= r_mis | w_mis_bit;
              if (r_bit_idx == LP_IDX_LAST) begin
                r_state <= ST_RESOLVE;
              end else begin
                r_bit_idx <= r_bit_idx + IDX_W'(1);
              end
            end else begin
              // Truncated frame: drop it without charging a try.
              r_state   <= ST_ARMED;
              r_bit_idx <= '0;
            end
          end
          ST_RESOLVE: begin
            r_bit_idx <= '0;
            if (!r_mis) begin
              r_match <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_try <= r_try + TRY_W'(1);
              if (r_try == LP_TRY_LAST) begin
                r_timeout <= 1'b1;
                r_state   <= ST_IDLE;
              end else begin
                r_state <= ST_ARMED;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_POSCNT        = w_poscnt;
  assign o_PGCMP_BUSY    = (r_state != ST_IDLE);
  assign o_PGCMP_MATCH   = r_match;
  assign o_PGCMP_TIMEOUT = r_timeout;
  assign o_DBG           = '{state: r_state, bit_idx: r_bit_idx, try_cnt: r_try, mismatch: r_mis};

endmodule

// File: tb/tb_k005297_pgcmp.sv
// Self-checking bench for k005297_pgcmp: rotation-level driver, frame-level
// reference model (which frame should match, if any) and per-scenario tasks.
module tb_k005297_pgcmp;
  import k005297_pkg::*;

  localparam int PAGE_MAX = 2052;
  localparam int TRY_MAX  = 2053;
  localparam int NPOS     = PAGE_MAX + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcen_n = 1'b1;
  logic [19:0] rot_n = '1;
  logic        shift = 1'b0, lsb = 1'b0, clr = 1'b0, pos_en = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [11:0] poscnt;
  logic        busy, match, timeout;
  pgcmp_dbg_t  dbg;

  int checks = 0;
  int failures = 0;
  int model_cnt = 0;
  int pos_err = 0;
  bit gaps_on = 1'b1;
  logic busy_trace [20];

  always #5 clk = ~clk;

  k005297_pgcmp #(.PAGE_MAX(PAGE_MAX), .TRY_MAX(TRY_MAX)) dut (
    .i_MCLK          (clk),
    .i_SYS_RST_n     (rst_n),
    .i_CLK2M_PCEN_n  (pcen_n),
    .i_ROT20_n       (rot_n),
    .i_PGREG_SR_SHIFT(shift),
    .i_PGREG_SR_LSB  (lsb),
    .i_POSCNT_CLR    (clr),
    .i_POSCNT_EN     (pos_en),
    .i_CMP_START     (start),
    .i_CMP_ABORT     (abort),
    .o_POSCNT        (poscnt),
    .o_PGCMP_BUSY    (busy),
    .o_PGCMP_MATCH   (match),
    .o_PGCMP_TIMEOUT (timeout),
    .o_DBG           (dbg)
  );

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // First frame index k (0-based) whose position equals the page, or -1 if none within TRY_MAX frames.
  function automatic int predict(input int page, input int c0);
    for (int k = 0; k < TRY_MAX; k++)
      if ((c0 + k) % NPOS == page) return k;
    return -1;
  endfunction

  // One enable cycle, optionally preceded by idle MCLK cycles carrying junk inputs.
  task automatic tick();
    logic [19:0] s_rot;
    logic [5:0]  s_ctl;
    int n;
    n = gaps_on ? $urandom_range(0, 2) : 0;
    s_rot = rot_n;
    s_ctl = {shift, lsb, clr, pos_en, start, abort};
    pcen_n = 1'b1;
    for (int i = 0; i < n; i++) begin
      rot_n = 20'($urandom);
      {shift, lsb, clr, pos_en, start, abort} = 6'($urandom);
      @(posedge clk); #1;
    end
    rot_n = s_rot;
    {shift, lsb, clr, pos_en, start, abort} = s_ctl;
    pcen_n = 1'b0;
    @(posedge clk); #1;
    pcen_n = 1'b1;
    if (clr) model_cnt = 0;
    else if (!rot_n[SLOT_CNT_ADV] && pos_en) model_cnt = (model_cnt + 1) % NPOS;
    if (int'(poscnt) != model_cnt) pos_err++;
  endtask

  task automatic clr_pulse();
    rot_n = '1; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic fast_advance(input int n);
    bit g;
    g = gaps_on; gaps_on = 1'b0;
    rot_n = '1; rot_n[SLOT_CNT_ADV] = 1'b0; pos_en = 1'b1;
    repeat (n) tick();
    rot_n = '1; gaps_on = g;
  endtask

  task automatic arm();
    rot_n = '1; shift = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_rotation(input logic [11:0] page, input int nbits, input int last_slot,
                             output int m_slot, output int m_cnt, output bit to_seen);
    m_slot = -1; m_cnt = 0; to_seen = 1'b0;
    for (int s = 0; s <= last_slot; s++) begin
      rot_n = '1; rot_n[s] = 1'b0;
      shift = (s < nbits);
      lsb = 1'b0;
      if (s < 12) lsb = page[s];
      tick();
      busy_trace[s] = busy;
      if (match) begin m_cnt++; if (m_slot < 0) m_slot = s; end
      if (timeout) to_seen = 1'b1;
    end
    shift = 1'b0; lsb = 1'b0; rot_n = '1;
  endtask

  task automatic run_search(input logic [11:0] page, input int max_rot,
                            output int m_rot, output int m_slot, output int m_tot, output int to_rot);
    int ms, mc; bit ts;
    m_rot = -1; m_slot = -1; m_tot = 0; to_rot = -1;
    for (int r = 0; r < max_rot; r++) begin
      do_rotation(page, 12, 19, ms, mc, ts);
      m_tot += mc;
      if (mc > 0 && m_rot < 0) begin m_rot = r; m_slot = ms; end
      if (ts && to_rot < 0) to_rot = r;
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, match, timeout} !== 3'b000 || poscnt !== 12'd0) begin
      failures++; $display("FAIL reset_outputs got busy/match/to=%b%b%b poscnt=%0d exp 000/0", busy, match, timeout, poscnt);
    end
    @(negedge clk); rst_n = 1'b1;
    model_cnt = 0;
    repeat (3) tick();
    checks++; if (dbg.state !== ST_IDLE || poscnt !== 12'd0) begin
      failures++; $display("FAIL reset_idle got state=%0d poscnt=%0d exp state=0 poscnt=0", dbg.state, poscnt);
    end
  endtask

  task automatic test_reset_mid();
    int ms, mc; bit ts;
    logic [11:0] page;
    fast_advance($urandom_range(10, 200));
    arm();
    page = 12'($urandom);
    do_rotation(page, 12, 5, ms, mc, ts);
    checks++; if (dbg.state !== ST_SHIFTIN) begin
      failures++; $display("FAIL reset_mid_pre got state=%0d exp=%0d", dbg.state, ST_SHIFTIN);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, match, timeout} !== 3'b000 || poscnt !== 12'd0) begin
      failures++; $display("FAIL reset_mid got busy/match/to=%b%b%b poscnt=%0d exp 000/0", busy, match, timeout, poscnt);
    end
    @(negedge clk); rst_n = 1'b1; model_cnt = 0;
    fast_advance($urandom_range(1, 50));
    arm();
    do_rotation(12'(model_cnt), 12, 12, ms, mc, ts);
    checks++; if (match !== 1'b1) begin
      failures++; $display("FAIL reset_match_pre got match=%b exp=1", match);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (match !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_match_kill got match=%b busy=%b exp 0 0", match, busy);
    end
    @(negedge clk); rst_n = 1'b1; model_cnt = 0;
  endtask

  task automatic test_match_first();
    int mr, ms, mt, tr;
    clr_pulse();
    fast_advance(12'h123);
    checks++; if (poscnt !== 12'h123) begin
      failures++; $display("FAIL preset_123 got=%0h exp=123", poscnt);
    end
    arm();
    checks++; if (busy !== 1'b1) begin
      failures++; $display("FAIL arm_busy got=%b exp=1", busy);
    end
    run_search(12'h123, 3, mr, ms, mt, tr);
    checks++; if (mr !== 0 || ms !== SHIFT_LAST + 1 || mt !== 1) begin
      failures++; $display("FAIL match_first got rot=%0d slot=%0d pulses=%0d exp 0/12/1", mr, ms, mt);
    end
    checks++; if (busy_trace[11] !== 1'b1 || busy_trace[12] !== 1'b0 || timeout !== 1'b0) begin
      failures++; $display("FAIL match_first_busy got b11=%b b12=%b to=%b exp 1/0/0", busy_trace[11], busy_trace[12], timeout);
    end
  endtask

  task automatic test_retry();
    int ms, mc; bit ts;
    clr_pulse();
    fast_advance(2);
    arm();
    for (int r = 0; r < 3; r++) begin
      do_rotation(12'h005, 12, 19, ms, mc, ts);
      checks++; if (mc !== 0) begin
        failures++; $display("FAIL retry_nomatch frame=%0d got pulses=%0d exp=0", r, mc);
      end
    end
    checks++; if (dbg.try_cnt !== 12'd3 || dbg.state !== ST_ARMED || poscnt !== 12'h005) begin
      failures++; $display("FAIL retry_tries got try=%0d state=%0d pos=%0d exp 3/1/5", dbg.try_cnt, dbg.state, poscnt);
    end
    arm();
    checks++; if (dbg.try_cnt !== 12'd3) begin
      failures++; $display("FAIL start_ignored got try=%0d exp=3", dbg.try_cnt);
    end
    do_rotation(12'h005, 12, 19, ms, mc, ts);
    checks++; if (mc !== 1 || ms !== 12 || busy !== 1'b0) begin
      failures++; $display("FAIL retry_match got pulses=%0d slot=%0d busy=%b exp 1/12/0", mc, ms, busy);
    end
  endtask

  task automatic test_random_pages();
    int mr, ms, mt, tr, exp_k, page;
    for (int it = 0; it < 5; it++) begin
      clr_pulse();
      fast_advance($urandom_range(0, PAGE_MAX));
      page = (model_cnt + $urandom_range(0, 4)) % NPOS;
      arm();
      exp_k = predict(page, model_cnt);
      run_search(12'(page), 8, mr, ms, mt, tr);
      checks++; if (mr !== exp_k || mt !== 1 || ms !== 12) begin
        failures++; $display("FAIL random_page page=%0d got rot=%0d pulses=%0d slot=%0d exp %0d/1/12", page, mr, mt, ms, exp_k);
      end
    end
  endtask

  task automatic test_wrap();
    int mr, ms, mt, tr;
    clr_pulse();
    fast_advance(PAGE_MAX);
    checks++; if (poscnt !== 12'd2052) begin
      failures++; $display("FAIL wrap_max got=%0d exp=2052", poscnt);
    end
    fast_advance(1);
    checks++; if (poscnt !== 12'd0) begin
      failures++; $display("FAIL wrap_zero got=%0d exp=0", poscnt);
    end
    clr_pulse();
    fast_advance(2051);
    arm();
    run_search(12'h000, 5, mr, ms, mt, tr);
    checks++; if (mr !== 2 || mt !== 1) begin
      failures++; $display("FAIL wrap_match got rot=%0d pulses=%0d exp 2/1", mr, mt);
    end
  endtask

  task automatic test_simultaneous();
    int ms, mc, c0; bit ts;
    logic [11:0] page;
    fast_advance($urandom_range(5, 100));
    rot_n = '1; rot_n[SLOT_CNT_ADV] = 1'b0; pos_en = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; rot_n = '1;
    checks++; if (poscnt !== 12'd0) begin
      failures++; $display("FAIL clr_vs_en got=%0d exp=0", poscnt);
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || dbg.state !== ST_IDLE) begin
      failures++; $display("FAIL abort_start got busy=%b state=%0d exp 0/0", busy, dbg.state);
    end
    fast_advance($urandom_range(0, 40));
    arm();
    c0 = model_cnt;
    page = 12'((c0 + 2) % NPOS);
    do_rotation(page, 12, 19, ms, mc, ts);
    do_rotation(page, 6, 19, ms, mc, ts);
    checks++; if (dbg.try_cnt !== 12'd1 || dbg.state !== ST_ARMED || mc !== 0) begin
      failures++; $display("FAIL truncated got try=%0d state=%0d pulses=%0d exp 1/1/0", dbg.try_cnt, dbg.state, mc);
    end
    do_rotation(page, 12, 19, ms, mc, ts);
    checks++; if (mc !== 1 || ms !== 12) begin
      failures++; $display("FAIL after_trunc got pulses=%0d slot=%0d exp 1/12", mc, ms);
    end
    arm();
    page = 12'(model_cnt);
    do_rotation(page, 12, 5, ms, mc, ts);
    rot_n = '1; rot_n[6] = 1'b0; shift = 1'b1; lsb = page[6]; abort = 1'b1;
    tick();
    abort = 1'b0; shift = 1'b0; rot_n = '1;
    checks++; if (busy !== 1'b0 || match !== 1'b0) begin
      failures++; $display("FAIL abort_mid got busy=%b match=%b exp 0/0", busy, match);
    end
    do_rotation(page, 12, 19, ms, mc, ts);
    checks++; if (mc !== 0) begin
      failures++; $display("FAIL abort_quiet got pulses=%0d exp=0", mc);
    end
  endtask

  task automatic test_timeout();
    int mr, ms, mt, tr, mc; bit ts;
    gaps_on = 1'b0;
    arm();
    run_search(12'hFFF, TRY_MAX + 2, mr, ms, mt, tr);
    checks++; if (mt !== 0 || tr !== TRY_MAX - 1) begin
      failures++; $display("FAIL timeout_frame got pulses=%0d to_rot=%0d exp 0/%0d", mt, tr, TRY_MAX - 1);
    end
    checks++; if (timeout !== 1'b1 || busy !== 1'b0 || dbg.try_cnt !== 12'(TRY_MAX)) begin
      failures++; $display("FAIL timeout_state got to=%b busy=%b try=%0d exp 1/0/%0d", timeout, busy, dbg.try_cnt, TRY_MAX);
    end
    gaps_on = 1'b1;
    do_rotation(12'($urandom), 12, 19, ms, mc, ts);
    checks++; if (timeout !== 1'b1) begin
      failures++; $display("FAIL timeout_sticky got=%b exp=1", timeout);
    end
    arm();
    checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL timeout_clear got to=%b busy=%b exp 0/1", timeout, busy);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_match_first();
    test_retry();
    test_random_pages();
    test_wrap();
    test_simultaneous();
    test_timeout();
    checks++; if (pos_err !== 0) begin
      failures++; $display("FAIL poscnt_track got %0d disagreeing enable cycles exp 0", pos_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
